// File: rtl/seq_shift_add_mult_ctrl.sv
// seq_shift_add_mult_ctrl: iterative unsigned shift-and-add multiplier.
// One add/shift step per cycle with valid/ready handshakes on operands and product.
module seq_shift_add_mult_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t               r_state, w_next;
    logic [WIDTH-1:0]     r_mcand, r_acc, r_mplr;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_product, w_shift;
    logic [WIDTH:0]       w_sum;
    logic                 w_last, w_accept;
    assign w_accept = r_state == IDLE && start_valid;
    assign w_last   = r_cnt == CW'(WIDTH - 1);
    assign w_sum    = {1'b0, r_acc} + (r_mplr[0] ? {1'b0, r_mcand} : '0);
    // the sum's carry lands in the top of acc; the consumed multiplier bit falls off the bottom
    assign w_shift  = {w_sum, r_mplr[WIDTH-1:1]};
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end
    always_comb begin
        w_next = (w_accept)                   ? BUSY :
                 (r_state == BUSY && w_last)   ? DONE :
                 (r_state == DONE && res_ready) ? IDLE : r_state;
    end
    always_comb begin
        start_ready = r_state == IDLE;
        busy        = r_state == BUSY;
        res_valid   = r_state == DONE;
        product     = r_product;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand   <= '0;
            r_acc     <= '0;
            r_mplr    <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_mcand <= a;
            r_mplr  <= b;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (r_state == BUSY) begin
            {r_acc, r_mplr} <= w_shift;
            r_cnt           <= r_cnt + CW'(1);
            if (w_last)
                r_product <= w_shift;
        end
    end
endmodule

// File: doc/seq_shift_add_mult_ctrl.md
# seq_shift_add_mult_ctrl

Sequencing controller and datapath for an iterative shift-and-add multiplier built on the team's adder primitives. It accepts one operand pair through a valid/ready handshake. It then steps a single WIDTH-bit add/shift stage for WIDTH cycles and returns the 2·WIDTH-bit product through a second valid/ready handshake. It is the low-area alternative to the combinational array multipliers in the design and shares the same operand/product conventions.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- start_valid  in  1  operand pair on a/b is valid.
- start_ready  out  1  block can accept an operand pair.
- a  in  WIDTH  multiplicand, unsigned.
- b  in  WIDTH  multiplier, unsigned.
- res_valid  out  1  product is valid.
- res_ready  in  1  consumer accepts the product.
- product  out  2·WIDTH  unsigned product a·b.
- busy  out  1  high while an iteration is in progress.

## Operation
- FSM states: IDLE, BUSY, DONE.
- Internal registers:
  - mcand (WIDTH)
  - acc (WIDTH)
  - mplr (WIDTH)
  - cnt (clog2(WIDTH+1) bits)
- IDLE:
  - start_ready=1.
  - On start_valid&&start_ready: mcand<=a, mplr<=b, acc<=0, cnt<=0, go to BUSY.
  - a and b are sampled only on this accept edge.
- BUSY, once per cycle:
  - Compute sum = {1'b0,acc} + (mplr[0] ? mcand : 0), WIDTH+1 bits.
  - Then {acc,mplr} <= {sum,mplr[WIDTH-1:1]}, a right shift of the (2·WIDTH+1)-bit concatenation keeping the low 2·WIDTH bits.
  - Then cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: load product<={next acc, next mplr} and go to DONE.
- DONE:
  - res_valid=1; product is held stable.
  - On res_ready, go to IDLE.
  - start_ready=0, so a simultaneous start_valid is not accepted. It is accepted in the following IDLE cycle.
- start_ready=0 and busy=1 in BUSY. start_valid is ignored in BUSY and DONE.
- product holds its last value in IDLE until the next DONE load; it is not cleared on accept.
- Arithmetic: the sum never exceeds WIDTH+1 bits. The final product is exact modulo 2^(2·WIDTH), and there is no overflow for unsigned operands.
- Zero operands take the full WIDTH iterations; there is no early termination.

## Timing
- Reset values (any cycle with rst_n=0 at the edge):
  - state=IDLE
  - start_ready=1 (decoded from state)
  - res_valid=0
  - busy=0
  - product=0
  - acc=0, mplr=0, mcand=0, cnt=0
- Reset mid-operation (BUSY or DONE) aborts the operation. The pending result is discarded and never presented.
- All outputs are decoded from registered state or are registers. There are no combinational paths from inputs to outputs.
- Latency: accept edge E. BUSY covers the cycles after edges E..E+WIDTH-1. res_valid is high in the cycle after edge E+WIDTH.
- For WIDTH=8, res_valid rises 9 cycles after the accept cycle.
- Throughput with res_ready tied high: one operation per WIDTH+2 cycles (accept, WIDTH iterations, DONE, IDLE).
- Backpressure: res_valid and product remain stable while res_ready=0, indefinitely.

## Test plan
- WIDTH=8, reset, then a=13, b=11, start_valid pulse, res_ready=1. Required: product=0x008F (143); res_valid rises exactly 9 cycles after the accept cycle; busy high for exactly 8 cycles.
- a=0xFF, b=0xFF. Required: product=0xFE01. Also a=0x00, b=0xA5, which requires product=0x0000 with the same 8-iteration latency.
- Hold res_ready=0 for 20 cycles in DONE, toggling start_valid with new operands throughout. Required: product stays 0x008F, res_valid stays 1, start_ready stays 0, and no new operation starts. The new pair is accepted only in the cycle after DONE→IDLE.
- Assert start_valid continuously with changing a/b during BUSY. Required: the result equals the product of the pair present on the accept edge only.
- Drive rst_n=0 for one cycle at BUSY iteration 4. Required: the next cycle shows state IDLE, start_ready=1, busy=0, res_valid=0, product=0. A fresh a=7, b=6 then yields product=42.
- Random unsigned regression at WIDTH=4, 8 and 16, with 1000 pairs each and random res_ready backpressure. Required: every product matches a·b, and exactly one res_valid handshake occurs per accepted start.
